csa_pipe_add32: RTL and testbench

CSA_PIPE_ADD32 -- requirements
Module: csa_pipe_add32

---
 rtl/csa_pkg.sv | 6 +
 rtl/skip_seg.sv | 22 ++
 rtl/csa_pipe_add32.sv | 120 ++++++++++++
 tb/tb_csa_pipe_add32.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants for the pipelined 32-bit carry-skip adder.
package csa_pkg;
    localparam int ADD_W    = 32;
    localparam int LO_W_DEF = 14;
    localparam int HI_W_DEF = 18;
endpackage

// File: rtl/skip_seg.sv
// Carry-skip segment: ripple adds the slice. When every bit propagates,
// the carry out is taken straight from the carry in.
module skip_seg
#(
    parameter int W = 18
)
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         p,
    output logic [W-1:0] s,
    output logic         co
);
    logic w_rc;

    // ripple sum of the segment plus its natural carry out
    assign {w_rc, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

    // skip mux: a fully propagating group passes ci unchanged
    assign co = p ? ci : w_rc;
endmodule

// File: rtl/csa_pipe_add32.sv
// Two-stage pipelined 32-bit adder with a carry-skip upper segment and
// valid/ready handshakes on both sides.
// Optional feature: define CSA_PIPE_OVF_EN to add the registered signed
// overflow output ovf.
module csa_pipe_add32
    import csa_pkg::*;
#(
    parameter int LO_W = LO_W_DEF,
    parameter int HI_W = HI_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADD_W-1:0] sum,
    output logic             cout
`ifdef CSA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    // stage 1 state
    logic            r_s1_valid;
    logic [LO_W-1:0] r_s1_lo_sum;
    logic            r_s1_c_lo;
    logic [HI_W-1:0] r_s1_a_hi;
    logic [HI_W-1:0] r_s1_b_hi;
    logic            r_s1_p;

    // stage 2 state
    logic             r_out_valid;
    logic [ADD_W-1:0] r_sum;
    logic             r_cout;

    logic            w_s2_adv;
    logic            w_c_lo;
    logic [LO_W-1:0] w_lo_sum;
    logic [HI_W-1:0] w_hi_sum;
    logic            w_hi_co;

    // stage 2 can take new data when empty or being drained this cycle
    assign w_s2_adv  = ~r_out_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    // low segment sum and carry from the live operands
    assign {w_c_lo, w_lo_sum} = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]}
                              + {{LO_W{1'b0}}, cin};

    // stage 1: capture low result, high slices and group propagate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_lo_sum <= '0;
            r_s1_c_lo   <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_b_hi   <= '0;
            r_s1_p      <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo_sum <= w_lo_sum;
                r_s1_c_lo   <= w_c_lo;
                r_s1_a_hi   <= a[ADD_W-1:LO_W];
                r_s1_b_hi   <= b[ADD_W-1:LO_W];
                r_s1_p      <= &(a[ADD_W-1:LO_W] ^ b[ADD_W-1:LO_W]);
            end
        end
    end

    skip_seg #(.W(HI_W)) u_hi (
        .a  (r_s1_a_hi),
        .b  (r_s1_b_hi),
        .ci (r_s1_c_lo),
        .p  (r_s1_p),
        .s  (w_hi_sum),
        .co (w_hi_co)
    );

    // stage 2: register the full result; hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= {w_hi_sum, r_s1_lo_sum};
                r_cout <= w_hi_co;
            end
        end
    end

`ifdef CSA_PIPE_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // operand signs come from the stage-1 high slices, result sign from the new sum
    assign w_ovf = (r_s1_a_hi[HI_W-1] == r_s1_b_hi[HI_W-1]) &
                   (w_hi_sum[HI_W-1] != r_s1_a_hi[HI_W-1]);
    assign ovf   = r_ovf;

    // overflow flag registered alongside sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_s2_adv && r_s1_valid)
            r_ovf <= w_ovf;
    end
`endif
endmodule

// File: tb/tb_csa_pipe_add32.sv
// Directed bench for csa_pipe_add32: vector table plus handshake sequences.
module tb_csa_pipe_add32;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CSA_PIPE_OVF_EN
    logic        ovf;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs [9];

    csa_pipe_add32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv, input logic c);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = c;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h0000_3FFF, 32'h0000_0001, 1'b0, 32'h0000_4000, 1'b0};
        vecs[3] = '{32'hFFFF_C000, 32'h0000_4000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
        vecs[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0, 32'hA9AC_79AD, 1'b1};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // single-shot vectors: out_valid must be low after one edge, high after two
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("v%0d_lat1_valid", i), {31'b0, out_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
            chk($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].exp_cout});
        end
        @(negedge clk);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // back-to-back: four accepts, results 2,4,6,8 on consecutive cycles
        drive(1'b1, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        chk("b2b_rdy1", {31'b0, in_ready}, 32'd1);
        chk("b2b_v_n1", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 32'd2, 32'd2, 1'b0);
        @(negedge clk);
        chk("b2b_v_n2", {31'b0, out_valid}, 32'd1);
        chk("b2b_sum2", sum, 32'd2);
        drive(1'b1, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        chk("b2b_v_n3", {31'b0, out_valid}, 32'd1);
        chk("b2b_sum4", sum, 32'd4);
        drive(1'b1, 32'd4, 32'd4, 1'b0);
        @(negedge clk);
        chk("b2b_v_n4", {31'b0, out_valid}, 32'd1);
        chk("b2b_sum6", sum, 32'd6);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("b2b_v_n5", {31'b0, out_valid}, 32'd1);
        chk("b2b_sum8", sum, 32'd8);
        @(negedge clk);
        chk("b2b_empty", {31'b0, out_valid}, 32'd0);

        // backpressure: out_ready low for 5 edges, three operands offered
        out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd1, 1'b0);
        @(negedge clk);
        chk("bp_rdy_after1", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'd20, 32'd2, 1'b0);
        @(negedge clk);
        chk("bp_rdy_full", {31'b0, in_ready}, 32'd0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_sum11", sum, 32'd11);
        drive(1'b1, 32'd30, 32'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_rdy%0d", k), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp_hold_sum%0d", k), sum, 32'd11);
            chk($sformatf("bp_hold_v%0d", k), {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("bp_out22", sum, 32'd22);
        chk("bp_v22", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_out33", sum, 32'd33);
        chk("bp_v33", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // reset one cycle after an accept discards the operand
        drive(1'b1, 32'd100, 32'd200, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_sum", sum, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rdy", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mrst_nov%0d", k), {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end

`ifdef CSA_PIPE_OVF_EN
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("ovf_valid", {31'b0, out_valid}, 32'd1);
        chk("ovf_sum", sum, 32'h8000_0000);
        chk("ovf_flag", {31'b0, ovf}, 32'd1);
        chk("ovf_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
